// File: rtl/mlops_pkg.sv
// Shared constants and small helpers for the vector activation datapath.
package mlops_pkg;

    localparam int NBITS_DEFAULT = 8;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Increment with an explicit wrap so non-power-of-two depths work.
    function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned last);
        return (ptr == last) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/v_chunk_fifo_chunk_ram.sv
// Simple dual-port chunk RAM: one write port, one registered read port.
module chunk_ram #(
    parameter int Width = 16,
    parameter int Depth = 8,
    parameter int AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_wr_en,
    input  logic [AddrW-1:0] i_wr_addr,
    input  logic [Width-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AddrW-1:0] i_rd_addr,
    output logic [Width-1:0] o_rd_data
);

    logic [Width-1:0] r_mem [Depth];
    logic [Width-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register holds between reads so the consumer sees a stable chunk.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/v_chunk_fifo.sv
// Chunk-granular FIFO feeding the vector activation stages; counts chunks, not vectors.
module v_chunk_fifo
    import mlops_pkg::*;
#(
    parameter int InVecLength = 8,
    parameter int WorkingRegs = 2,
    parameter int NBits       = NBITS_DEFAULT,
    parameter int Depth       = 2 * ceil_div(InVecLength, WorkingRegs)
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               wr_en,
    input  logic [WorkingRegs*NBits-1:0]       wr_data,
    input  logic                               rd_req,
    output logic [WorkingRegs*NBits-1:0]       rd_data,
    output logic                               rd_valid,
    output logic                               vector_ready,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(Depth+1)-1:0]         count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int ChunksPerVec = ceil_div(InVecLength, WorkingRegs);
    localparam int PtrW         = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW         = $clog2(Depth + 1);
    localparam int ChunkW       = WorkingRegs * NBits;

    localparam logic [CntW-1:0] DEPTH_C = CntW'(Depth);
    localparam logic [CntW-1:0] CPV_C   = CntW'(ChunksPerVec);

    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            r_rd_valid;
    logic            r_overflow;
    logic            r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_do;
    logic w_wr_accept;

    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    assign w_rd_do     = rd_req && !w_empty;
    // A read on the same edge frees a slot, so a full FIFO can still accept.
    assign w_wr_accept = wr_en && (!w_full || w_rd_do);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= PtrW'(ptr_wrap(32'(r_wr_ptr), 32'(Depth - 1)));
            end
            if (w_rd_do) begin
                r_rd_ptr <= PtrW'(ptr_wrap(32'(r_rd_ptr), 32'(Depth - 1)));
            end
            r_count    <= r_count + CntW'(w_wr_accept) - CntW'(w_rd_do);
            r_rd_valid <= w_rd_do;
            if (wr_en && !w_wr_accept) begin
                r_overflow <= 1'b1;
            end
            if (rd_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    chunk_ram #(
        .Width (ChunkW),
        .Depth (Depth),
        .AddrW (PtrW)
    ) u_ram (
        .i_clk     (clk_in),
        .i_srst    (rst_in),
        .i_wr_en   (w_wr_accept && !rst_in),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_do && !rst_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign vector_ready = (r_count >= CPV_C);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_v_chunk_fifo.sv
// Scoreboard bench: one harness with Depth=8 for the directed/random tests, one with Depth=6 for wrap.
module tb_v_chunk_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_h
        localparam int D   = (gi == 0) ? 8 : 6;
        localparam int IVL = (gi == 0) ? 8 : 6;
        localparam int CPV = (IVL + 1) / 2;

        logic                     rst = 1'b1;
        logic                     wr_en = 1'b0;
        logic [15:0]              wr_data = '0;
        logic                     rd_req = 1'b0;
        logic [15:0]              rd_data;
        logic                     rd_valid;
        logic                     vector_ready;
        logic                     full;
        logic                     empty;
        logic [$clog2(D+1)-1:0]   count;
        logic                     overflow;
        logic                     underflow;
        logic                     r_done = 1'b0;

        // Reference model: FIFO contents, sticky flags, last popped chunk.
        logic [15:0] mq [$];
        logic [15:0] expq [$];
        logic        movf = 1'b0;
        logic        munf = 1'b0;
        logic        mv = 1'b0;
        logic [15:0] mlast = '0;

        v_chunk_fifo #(
            .InVecLength (IVL),
            .WorkingRegs (2),
            .NBits       (8),
            .Depth       (D)
        ) u_dut (
            .clk_in       (clk),
            .rst_in       (rst),
            .wr_en        (wr_en),
            .wr_data      (wr_data),
            .rd_req       (rd_req),
            .rd_data      (rd_data),
            .rd_valid     (rd_valid),
            .vector_ready (vector_ready),
            .full         (full),
            .empty        (empty),
            .count        (count),
            .overflow     (overflow),
            .underflow    (underflow)
        );

        task automatic step(input logic r, input logic we, input logic [15:0] wd, input logic rr);
            int          n;
            logic        rdo;
            logic        acc;
            logic [15:0] e;
            rst     = r;
            wr_en   = we;
            wr_data = wd;
            rd_req  = rr;
            @(posedge clk);
            if (r) begin
                mq.delete();
                movf  = 1'b0;
                munf  = 1'b0;
                mv    = 1'b0;
                mlast = '0;
            end else begin
                n   = mq.size();
                rdo = rr && (n != 0);
                acc = we && ((n != D) || rdo);
                if (rdo) begin
                    e = mq.pop_front();
                    expq.push_back(e);
                    mlast = e;
                end
                if (acc) mq.push_back(wd);
                if (we && !acc) movf = 1'b1;
                if (rr && (n == 0)) munf = 1'b1;
                mv = rdo;
            end
            #1;
            n = mq.size();
            check($sformatf("[%0d] count", gi), int'(count), n);
            check($sformatf("[%0d] full", gi), int'(full), int'(n == D));
            check($sformatf("[%0d] empty", gi), int'(empty), int'(n == 0));
            check($sformatf("[%0d] vector_ready", gi), int'(vector_ready), int'(n >= CPV));
            check($sformatf("[%0d] overflow", gi), int'(overflow), int'(movf));
            check($sformatf("[%0d] underflow", gi), int'(underflow), int'(munf));
            check($sformatf("[%0d] rd_valid", gi), int'(rd_valid), int'(mv));
            if (!mv) check($sformatf("[%0d] rd_data_hold", gi), int'(rd_data), int'(mlast));
        endtask

        task automatic idle();
            step(1'b0, 1'b0, 16'h0, 1'b0);
        endtask

        task automatic rand_run(input int cycles);
            for (int i = 0; i < cycles; i++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            end
        endtask

        task automatic drain_and_close();
            repeat (D + 1) step(1'b0, 1'b0, 16'h0, 1'b1);
            idle();
            idle();
            check($sformatf("[%0d] scoreboard_left", gi), expq.size(), 0);
        endtask

        // Monitor: every presented chunk must match the oldest expected one.
        always @(negedge clk) begin
            logic [15:0] e_mon;
            if (rd_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL [%0d] unexpected_pop: got 0x%04h expected no chunk", gi, rd_data);
                end else begin
                    e_mon = expq.pop_front();
                    check($sformatf("[%0d] rd_data", gi), int'(rd_data), int'(e_mon));
                    $display("[%0d] pop got 0x%04h expected 0x%04h", gi, rd_data, e_mon);
                end
            end
        end

        if (gi == 0) begin : g_seq
            initial begin
                step(1'b1, 1'b0, 16'h0, 1'b0);
                step(1'b1, 1'b0, 16'h0, 1'b0);
                check("reset_rd_data", int'(rd_data), 0);
                check("reset_empty", int'(empty), 1);
                // Single vector through.
                for (int i = 0; i < 4; i++) step(1'b0, 1'b1, {8'(2*i+1), 8'(2*i+2)}, 1'b0);
                check("t1_vector_ready", int'(vector_ready), 1);
                check("t1_count", int'(count), 4);
                repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1);
                idle();
                check("t1_empty", int'(empty), 1);
                check("t1_vector_ready_low", int'(vector_ready), 0);
                // Fill, then overflow.
                for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
                check("t2_full", int'(full), 1);
                step(1'b0, 1'b1, 16'h0009, 1'b0);
                check("t2_overflow", int'(overflow), 1);
                check("t2_count", int'(count), 8);
                repeat (8) step(1'b0, 1'b0, 16'h0, 1'b1);
                idle();
                // Simultaneous read and write while full.
                for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0010 + 16'(i), 1'b0);
                step(1'b0, 1'b1, 16'h7F7F, 1'b1);
                check("t3_count", int'(count), 8);
                repeat (8) step(1'b0, 1'b0, 16'h0, 1'b1);
                idle();
                // Read on empty with a concurrent write.
                step(1'b0, 1'b1, 16'hFF80, 1'b1);
                check("t4_underflow", int'(underflow), 1);
                check("t4_rd_valid", int'(rd_valid), 0);
                check("t4_count", int'(count), 1);
                step(1'b0, 1'b0, 16'h0, 1'b1);
                idle();
                // Reset mid-operation with a concurrent write.
                for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0A00 + 16'(i), 1'b0);
                repeat (2) step(1'b0, 1'b0, 16'h0, 1'b1);
                step(1'b1, 1'b1, 16'hABCD, 1'b0);
                check("t6_count", int'(count), 0);
                check("t6_empty", int'(empty), 1);
                check("t6_rd_valid", int'(rd_valid), 0);
                check("t6_overflow", int'(overflow), 0);
                check("t6_underflow", int'(underflow), 0);
                idle();
                rand_run(400);
                drain_and_close();
                r_done = 1'b1;
            end
        end else begin : g_seq
            initial begin
                int npush;
                int n;
                int sel;
                step(1'b1, 1'b0, 16'h0, 1'b0);
                step(1'b1, 1'b0, 16'h0, 1'b0);
                step(1'b0, 1'b1, 16'd100, 1'b0);
                npush = 1;
                // Keep occupancy in 1..5 so pointers wrap several times.
                while (npush < 21) begin
                    n = mq.size();
                    if (n <= 1) sel = 0;
                    else if (n >= 5) sel = 1;
                    else sel = $urandom_range(0, 2);
                    if (sel == 1) begin
                        step(1'b0, 1'b0, 16'h0, 1'b1);
                    end else begin
                        step(1'b0, 1'b1, 16'd100 + 16'(npush), sel == 2);
                        npush++;
                    end
                end
                drain_and_close();
                rand_run(400);
                drain_and_close();
                r_done = 1'b1;
            end
        end
    end

    initial begin
        wait (g_h[0].r_done && g_h[1].r_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected both sequences done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
